// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM encoding and next-pc source tags for the fetch controller.
package fetch_ctrl_pkg;

  localparam int STALL_BUS     = 2;
  localparam int BR_BUS_W      = 33;
  localparam int IF12IF2_BUS_W = 33;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_FLUSH  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_HOLD   = 2'd2,
    NPC_SEQ    = 2'd3
  } npc_src_e;

  // Instruction addresses must be word aligned; anything else is a fetch error.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc_sel.sv
// Next-pc priority mux: flush > branch > hold > sequential (pc + 4, wraps).
module npc_sel
  import fetch_ctrl_pkg::*;
(
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic        hold,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output npc_src_e    src
);

  always_comb begin
    npc = pc + 32'd4;
    src = NPC_SEQ;
    if (flush) begin
      npc = flush_pc;
      src = NPC_FLUSH;
    end else if (br_e) begin
      npc = br_addr;
      src = NPC_BRANCH;
    end else if (hold) begin
      npc = pc;
      src = NPC_HOLD;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC-stage fetch controller: owns pc_r, drives the instruction SRAM read and
// hands {pc_valid, pc} to IF2; handles stalls, branch/flush redirects and errors.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          STALL_W  = STALL_BUS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [STALL_W-1:0]       stall,
  input  logic [BR_BUS_W-1:0]      br_bus,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  output logic                     inst_sram_en,
  output logic [31:0]              inst_sram_addr,
  output logic [IF12IF2_BUS_W-1:0] if12if2_bus,
  output logic                     fetch_err,
  output logic [15:0]              redirect_cnt,
  output fetch_state_e             state_dbg
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic         fetch_err_r;
  logic [15:0]  redirect_cnt_r;

  logic         br_e;
  logic [31:0]  br_addr;
  logic         in_run;
  logic [31:0]  npc;
  npc_src_e     npc_src;
  logic         redirect;
  logic         unused_stall_hi;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign in_run  = (state_r == ST_RUN);
  // Only stall[0] affects the PC stage; the IF1/IF2 bit is consumed downstream.
  assign unused_stall_hi = ^stall;

  // Branches are only honoured while running; BOOT and ERR hold pc unless flushed.
  npc_sel u_npc_sel (
    .flush    (flush),
    .flush_pc (flush_pc),
    .br_e     (br_e & in_run),
    .br_addr  (br_addr),
    .hold     (stall[0] | ~in_run),
    .pc       (pc_r),
    .npc      (npc),
    .src      (npc_src)
  );

  assign redirect = (npc_src == NPC_FLUSH) || (npc_src == NPC_BRANCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_BOOT;
      pc_r           <= RESET_PC;
      fetch_err_r    <= 1'b0;
      redirect_cnt_r <= 16'd0;
    end else begin
      pc_r <= npc;
      if (redirect && (state_r != ST_BOOT) && (redirect_cnt_r != 16'hFFFF)) begin
        redirect_cnt_r <= redirect_cnt_r + 16'd1;
      end
      if (redirect && is_misaligned(npc)) begin
        state_r     <= ST_ERR;
        fetch_err_r <= 1'b1;
      end else begin
        case (state_r)
          ST_BOOT: state_r <= ST_RUN;
          ST_RUN:  state_r <= ST_RUN;
          ST_ERR:  if (redirect) state_r <= ST_RUN;
          default: state_r <= ST_BOOT;
        endcase
      end
    end
  end

  // Stalls keep the read enabled so IF2 re-captures the same line on release.
  assign inst_sram_en   = in_run;
  assign inst_sram_addr = {pc_r[31:3], 3'b000};
  assign if12if2_bus    = {in_run, pc_r};
  assign fetch_err      = fetch_err_r;
  assign redirect_cnt   = redirect_cnt_r;
  assign state_dbg      = state_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, directed corner sequences,
// and randomized traffic against an abstract fetch model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [STALL_BUS-1:0]     stall;
  logic [BR_BUS_W-1:0]      br_bus;
  logic                     flush;
  logic [31:0]              flush_pc;
  logic                     inst_sram_en;
  logic [31:0]              inst_sram_addr;
  logic [IF12IF2_BUS_W-1:0] if12if2_bus;
  logic                     fetch_err;
  logic [15:0]              redirect_cnt;
  fetch_state_e             state_dbg;

  fetch_ctrl #(.RESET_PC(RESET_PC), .STALL_W(STALL_BUS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .br_bus         (br_bus),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .if12if2_bus    (if12if2_bus),
    .fetch_err      (fetch_err),
    .redirect_cnt   (redirect_cnt),
    .state_dbg      (state_dbg)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_BOOT, M_RUN, M_ERR} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc;
  logic        m_err;
  int unsigned m_cnt;

  // Applies the fetch rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] target;
    logic        take;
    if (!rst_n) begin
      m_mode = M_BOOT;
      m_pc   = RESET_PC;
      m_err  = 1'b0;
      m_cnt  = 0;
      return;
    end
    take   = 1'b0;
    target = m_pc;
    if (flush) begin
      take = 1'b1;
      target = flush_pc;
    end else if (br_bus[32] && m_mode == M_RUN) begin
      take = 1'b1;
      target = br_bus[31:0];
    end
    if (take) begin
      if (m_mode != M_BOOT && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_pc = target;
      if (target % 4 != 0) begin
        m_mode = M_ERR;
        m_err  = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && !stall[0]) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic run;
    run = (m_mode == M_RUN);
    chk({tag, " en"},    64'(inst_sram_en),    64'(run));
    chk({tag, " valid"}, 64'(if12if2_bus[32]), 64'(run));
    chk({tag, " pc"},    64'(if12if2_bus[31:0]), 64'(m_pc));
    chk({tag, " addr"},  64'(inst_sram_addr),  64'(m_pc & 32'hFFFF_FFF8));
    chk({tag, " err"},   64'(fetch_err),       64'(m_err));
    chk({tag, " cnt"},   64'(redirect_cnt),    64'(m_cnt));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [1:0] st, input logic be, input logic [31:0] ba,
                       input logic fl, input logic [31:0] fp);
    stall    = st;
    br_bus   = {be, ba};
    flush    = fl;
    flush_pc = fp;
    model_edge();
    @(posedge clk);
    #1;
    stall    = '0;
    br_bus   = '0;
    flush    = 1'b0;
    flush_pc = '0;
  endtask

  task automatic idle();
    cycle(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  st;
    logic        be;
    logic [31:0] ba;
    logic        fl;
    logic [31:0] fp;
    logic [31:0] e_pc;
    logic        e_en;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    stall = '0; br_bus = '0; flush = 1'b0; flush_pc = '0;
    m_mode = M_BOOT; m_pc = RESET_PC; m_err = 1'b0; m_cnt = 0;

    // reset, with inputs asserted to show reset dominates
    rst_n = 1'b0;
    cycle(2'b01, 1'b1, 32'h8000_0400, 1'b0, 32'h0);
    cycle(2'b11, 1'b0, 32'h0, 1'b1, 32'h8000_0800);
    chk("reset en",    64'(inst_sram_en), 64'(0));
    chk("reset valid", 64'(if12if2_bus[32]), 64'(0));
    chk("reset addr",  64'(inst_sram_addr), 64'(32'h8000_0000));
    chk("reset err",   64'(fetch_err), 64'(0));
    chk("reset cnt",   64'(redirect_cnt), 64'(0));
    chk("reset state", 64'(state_dbg), 64'(ST_BOOT));

    // boot sequence
    rst_n = 1'b1;
    chk("boot en", 64'(inst_sram_en), 64'(0));
    idle();
    chk("boot c2 pc",   64'(if12if2_bus[31:0]), 64'(32'h8000_0000));
    chk("boot c2 addr", 64'(inst_sram_addr), 64'(32'h8000_0000));
    chk("boot c2 en",   64'(inst_sram_en), 64'(1));
    idle();
    chk("boot c3 pc",   64'(if12if2_bus[31:0]), 64'(32'h8000_0004));
    chk("boot c3 addr", 64'(inst_sram_addr), 64'(32'h8000_0000));
    idle();
    chk("boot c4 pc",   64'(if12if2_bus[31:0]), 64'(32'h8000_0008));
    chk("boot c4 addr", 64'(inst_sram_addr), 64'(32'h8000_0008));

    // table rows start from pc 8000_0008, count 0
    tbl[0]  = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_000C, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{2'b01, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_000C, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{2'b01, 1'b1, 32'h8000_0040, 1'b0, 32'h0,         32'h8000_0040, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{2'b10, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_0044, 1'b1, 1'b0, 16'd1};
    tbl[4]  = '{2'b00, 1'b1, 32'h8000_0090, 1'b1, 32'h8000_0080, 32'h8000_0080, 1'b1, 1'b0, 16'd2};
    tbl[5]  = '{2'b11, 1'b0, 32'h0,         1'b1, 32'h8000_0100, 32'h8000_0100, 1'b1, 1'b0, 16'd3};
    tbl[6]  = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_0104, 1'b1, 1'b0, 16'd3};
    tbl[7]  = '{2'b00, 1'b1, 32'h8000_0203, 1'b0, 32'h0,         32'h8000_0203, 1'b0, 1'b1, 16'd4};
    tbl[8]  = '{2'b00, 1'b1, 32'h8000_0300, 1'b0, 32'h0,         32'h8000_0203, 1'b0, 1'b1, 16'd4};
    tbl[9]  = '{2'b01, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_0203, 1'b0, 1'b1, 16'd4};
    tbl[10] = '{2'b00, 1'b0, 32'h0,         1'b1, 32'h8000_0301, 32'h8000_0301, 1'b0, 1'b1, 16'd5};
    tbl[11] = '{2'b00, 1'b0, 32'h0,         1'b1, 32'h8000_0400, 32'h8000_0400, 1'b1, 1'b1, 16'd6};
    tbl[12] = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_0404, 1'b1, 1'b1, 16'd6};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].st, tbl[i].be, tbl[i].ba, tbl[i].fl, tbl[i].fp);
      chk($sformatf("tbl%0d pc", i),    64'(if12if2_bus[31:0]), 64'(tbl[i].e_pc));
      chk($sformatf("tbl%0d en", i),    64'(inst_sram_en), 64'(tbl[i].e_en));
      chk($sformatf("tbl%0d valid", i), 64'(if12if2_bus[32]), 64'(tbl[i].e_en));
      chk($sformatf("tbl%0d addr", i),  64'(inst_sram_addr), 64'(tbl[i].e_pc & 32'hFFFF_FFF8));
      chk($sformatf("tbl%0d err", i),   64'(fetch_err), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d cnt", i),   64'(redirect_cnt), 64'(tbl[i].e_cnt));
    end

    // reset in the middle of a flush + branch + stall
    rst_n = 1'b0;
    cycle(2'b11, 1'b1, 32'h8000_0500, 1'b1, 32'h8000_0600);
    chk("midrst pc",  64'(if12if2_bus[31:0]), 64'(RESET_PC));
    chk("midrst en",  64'(inst_sram_en), 64'(0));
    chk("midrst err", 64'(fetch_err), 64'(0));
    chk("midrst cnt", 64'(redirect_cnt), 64'(0));
    rst_n = 1'b1;
    idle();

    // stall hold for three cycles at 8000_0010
    cycle(2'b00, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("stall%0d pc", i),   64'(if12if2_bus[31:0]), 64'(32'h8000_0010));
      chk($sformatf("stall%0d addr", i), 64'(inst_sram_addr), 64'(32'h8000_0010));
      chk($sformatf("stall%0d en", i),   64'(inst_sram_en), 64'(1));
    end
    idle();
    chk("stall release pc", 64'(if12if2_bus[31:0]), 64'(32'h8000_0014));

    // branch wins over stall
    cycle(2'b01, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
    chk("br+stall pc",  64'(if12if2_bus[31:0]), 64'(32'h8000_0100));
    chk("br+stall cnt", 64'(redirect_cnt), 64'(2));

    // flush wins over branch, counted once
    cycle(2'b00, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0200);
    chk("fl+br pc",  64'(if12if2_bus[31:0]), 64'(32'h8000_0200));
    chk("fl+br cnt", 64'(redirect_cnt), 64'(3));

    // misaligned branch, then flush out of ERR
    cycle(2'b00, 1'b1, 32'h8000_0102, 1'b0, 32'h0);
    chk("misal err",   64'(fetch_err), 64'(1));
    chk("misal en",    64'(inst_sram_en), 64'(0));
    chk("misal valid", 64'(if12if2_bus[32]), 64'(0));
    chk("misal pc",    64'(if12if2_bus[31:0]), 64'(32'h8000_0102));
    cycle(2'b00, 1'b0, 32'h0, 1'b1, 32'h8000_0000);
    chk("errexit en",  64'(inst_sram_en), 64'(1));
    chk("errexit pc",  64'(if12if2_bus[31:0]), 64'(32'h8000_0000));
    chk("errexit err", 64'(fetch_err), 64'(1));

    // pc wrap
    cycle(2'b00, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    chk("wrap0 pc", 64'(if12if2_bus[31:0]), 64'(32'hFFFF_FFF8));
    idle();
    chk("wrap1 pc", 64'(if12if2_bus[31:0]), 64'(32'hFFFF_FFFC));
    idle();
    chk("wrap2 pc", 64'(if12if2_bus[31:0]), 64'(32'h0000_0000));
    check_model("wrap");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  st;
      logic        be, fl;
      logic [31:0] ba, fp;
      st = 2'($urandom_range(0, 3));
      be = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 15) == 0);
      ba = 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2);
      fp = 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2);
      if ($urandom_range(0, 15) == 0) ba[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) fp[1:0] = 2'($urandom_range(1, 3));
      rst_n = ($urandom_range(0, 99) != 0);
      cycle(st, be, ba, fl, fp);
      rst_n = 1'b1;
      check_model($sformatf("rand%0d", i));
    end

    // drive the redirect counter up to saturation
    cycle(2'b00, 1'b0, 32'h0, 1'b1, 32'h8000_0000);
    for (int i = 0; i < 70000; i++) begin
      if (m_cnt >= 65534) break;
      cycle(2'b00, 1'b1, 32'h8000_0000 + 32'((i % 64) * 4), 1'b0, 32'h0);
    end
    chk("sat pre cnt", 64'(redirect_cnt), 64'(16'hFFFE));
    cycle(2'b00, 1'b1, 32'h8000_0040, 1'b0, 32'h0);
    chk("sat hit cnt", 64'(redirect_cnt), 64'(16'hFFFF));
    cycle(2'b00, 1'b1, 32'h8000_0080, 1'b0, 32'h0);
    chk("sat hold cnt", 64'(redirect_cnt), 64'(16'hFFFF));
    cycle(2'b00, 1'b1, 32'h8000_00C0, 1'b1, 32'h8000_0100);
    chk("sat hold2 cnt", 64'(redirect_cnt), 64'(16'hFFFF));
    check_model("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
